instr_decode_stage: RTL and testbench

//  Decode stage directly upstream of the ALU. Accepts 32-bit MIPS-style instruction words from fetch
//  via valid/ready and splits each into ALU operand selects (a=rs, b=rt), func_code and opcode,

---
 rtl/instr_decode_stage_if.sv | 28 ++
 rtl/instr_decode_stage.sv | 85 ++++++++
 tb/tb_instr_decode_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side instruction handshake plus decoded ALU-side bundle
interface instr_decode_stage_if #(parameter int CNT_W = 16);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             dec_valid;
    logic             dec_ready;
    logic [4:0]       a;
    logic [4:0]       b;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       func_code;
    logic [5:0]       opcode;
    logic [31:0]      imm_ext;
    logic [1:0]       instr_class;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;
    modport master (
        output instr_valid, instr, dec_ready,
        input  instr_ready, dec_valid, a, b, rd, shamt, func_code, opcode,
               imm_ext, instr_class, illegal, instr_count
    );
    modport slave (
        input  instr_valid, instr, dec_ready,
        output instr_ready, dec_valid, a, b, rd, shamt, func_code, opcode,
               imm_ext, instr_class, illegal, instr_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: MIPS-style field decode behind a 2-entry skid buffer, with delivered-instruction counter
module instr_decode_stage #(
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    instr_decode_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func_code;
        logic [5:0]  opcode;
        logic [31:0] imm_ext;
        logic [1:0]  instr_class;
        logic        illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        logic r_ok, s_ext, z_ext, j_op;
        r_ok  = w[31:26] == 6'h00 && (w[5:0] inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
        s_ext = w[31:26] inside {6'h08, 6'h23, 6'h2b, 6'h04};
        z_ext = w[31:26] inside {6'h0c, 6'h0d};
        j_op  = w[31:26] == 6'h02;
        d.a           = w[25:21];
        d.b           = w[20:16];
        d.rd          = w[15:11];
        d.shamt       = w[10:6];
        d.func_code   = w[5:0];
        d.opcode      = w[31:26];
        d.imm_ext     = s_ext ? {{16{w[15]}}, w[15:0]} : z_ext ? {16'h0, w[15:0]} : 32'h0;
        d.instr_class = r_ok ? 2'd0 : (s_ext || z_ext) ? 2'd1 : j_op ? 2'd2 : 2'd3;
        d.illegal     = !(r_ok || s_ext || z_ext || j_op);
        return d;
    endfunction

    state_t           state;
    dec_t             o;
    dec_t             skd;
    dec_t             dec_in;
    logic [CNT_W-1:0] cnt;
    logic             fire_in;
    logic             fire_out;

    // Ready depends on state alone so back-pressure never forms a comb path to fetch
    assign bus.instr_ready = state != FULL;
    assign bus.dec_valid   = state != EMPTY;
    assign fire_in         = bus.instr_valid && bus.instr_ready;
    assign fire_out        = bus.dec_valid && bus.dec_ready;
    assign dec_in          = decode(bus.instr);
    assign bus.instr_count = cnt;
    assign {bus.a, bus.b, bus.rd, bus.shamt, bus.func_code, bus.opcode,
            bus.imm_ext, bus.instr_class, bus.illegal} = o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            o     <= '0;
            skd   <= '0;
            cnt   <= '0;
        end else begin
            if (fire_out) cnt <= cnt + 1'b1;
            case (state)
                EMPTY: if (fire_in) begin
                    o     <= dec_in;
                    state <= ONE;
                end
                ONE: if (fire_in && fire_out) o <= dec_in;
                else if (fire_in) begin
                    skd   <= dec_in;
                    state <= FULL;
                end else if (fire_out) state <= EMPTY;
                FULL: if (fire_out) begin
                    o     <= skd;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed + random stimulus against a queue-based model of the decode stage
module tb_instr_decode_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        valid = 0;
    logic        ready = 0;
    logic [31:0] word = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cnt = 0;
    bit          took = 0;
    logic [31:0] q[$];

    instr_decode_stage_if #(.CNT_W(16)) i16 ();
    instr_decode_stage_if #(.CNT_W(4))  i4 ();
    assign i16.instr_valid = valid;
    assign i16.instr       = word;
    assign i16.dec_ready   = ready;
    assign i4.instr_valid  = valid;
    assign i4.instr        = word;
    assign i4.dec_ready    = ready;

    instr_decode_stage #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    instr_decode_stage #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(i4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {class, illegal, imm} from the legal-instruction tables
    function automatic logic [34:0] ref_dec(input logic [31:0] w);
        int rf[6] = '{0, 32, 34, 36, 37, 42};
        int so[4] = '{8, 35, 43, 4};
        int zo[2] = '{12, 13};
        int op = int'(w[31:26]);
        int fn = int'(w[5:0]);
        logic [1:0]  c = 2'd3;
        logic [31:0] imm = 32'h0;
        if (op == 0) foreach (rf[k]) if (fn == rf[k]) c = 2'd0;
        foreach (so[k]) if (op == so[k]) begin c = 2'd1; imm = 32'($signed(w[15:0])); end
        foreach (zo[k]) if (op == zo[k]) begin c = 2'd1; imm = {16'h0, w[15:0]}; end
        if (op == 2) c = 2'd2;
        return {c, c == 2'd3, imm};
    endfunction

    function automatic logic [31:0] rand_word();
        int ops[10] = '{0, 0, 8, 12, 13, 35, 43, 4, 2, 63};
        int rf[6]   = '{0, 32, 34, 36, 37, 42};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            w[31:26] = 6'(ops[$urandom_range(0, 9)]);
            if (w[31:26] == 6'h0 && $urandom_range(0, 2) != 0) w[5:0] = 6'(rf[$urandom_range(0, 5)]);
        end
        return w;
    endfunction

    task automatic step();
        logic fi, fo;
        logic [34:0] r;
        @(negedge clk);
        fi = i16.instr_valid && i16.instr_ready;
        fo = i16.dec_valid && i16.dec_ready;
        if (!rst && i16.dec_valid && q.size() > 0) begin
            r = ref_dec(q[0]);
            chk("raw_fields", 64'({i16.a, i16.b, i16.rd, i16.shamt, i16.func_code, i16.opcode}),
                64'({q[0][25:21], q[0][20:16], q[0][15:11], q[0][10:6], q[0][5:0], q[0][31:26]}));
            chk("class_ill_imm", 64'({i16.instr_class, i16.illegal, i16.imm_ext}), 64'(r));
        end
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (fo && q.size() > 0) begin
                void'(q.pop_front());
                cnt++;
            end
            if (fi) q.push_back(word);
        end
        took = fi && !rst;
        @(posedge clk);
        #1;
        chk("dec_valid", 64'(i16.dec_valid), 64'(q.size() > 0));
        chk("instr_ready", 64'(i16.instr_ready), 64'(q.size() < 2));
        chk("count16", 64'(i16.instr_count), 64'(cnt % 65536));
        chk("count4", 64'(i4.instr_count), 64'(cnt % 16));
        chk("dec_valid4", 64'(i4.dec_valid), 64'(q.size() > 0));
    endtask

    initial begin
        // Reset with a valid word presented: it must be ignored
        rst = 1; valid = 1; word = 32'h2145FFFF; ready = 0;
        step();
        chk("rst_fields", 64'({i16.a, i16.b, i16.rd, i16.shamt, i16.func_code, i16.opcode,
                               i16.instr_class, i16.illegal}), 64'h0);
        chk("rst_imm", 64'(i16.imm_ext), 64'h0);
        // R-type add
        rst = 0; valid = 1; word = 32'h00C52020; ready = 1;
        step();
        valid = 0;
        chk("t1_fields", 64'({i16.a, i16.b, i16.rd, i16.func_code, i16.opcode, i16.instr_class, i16.illegal}),
            64'({5'd6, 5'd5, 5'd4, 6'h20, 6'h00, 2'd0, 1'b0}));
        step();
        chk("t1_count", 64'(i16.instr_count), 64'd1);
        // addi sign-extends, andi zero-extends
        valid = 1; word = 32'h2145FFFF;
        step();
        chk("t2_addi", 64'({i16.opcode, i16.a, i16.b, i16.instr_class}), 64'({6'h08, 5'd10, 5'd5, 2'd1}));
        chk("t2_addi_imm", 64'(i16.imm_ext), 64'hFFFFFFFF);
        word = 32'h3145FFFF;
        step();
        chk("t2_andi_imm", 64'(i16.imm_ext), 64'h0000FFFF);
        valid = 0;
        step();
        // Back-pressure fills the skid; third word waits at fetch
        ready = 0; valid = 1; word = 32'h00C52020;
        step();
        word = 32'h2145FFFF;
        step();
        chk("t3_full", 64'(i16.instr_ready), 64'd0);
        word = 32'h3145FFFF;
        step();
        chk("t3_held", 64'(took), 64'd0);
        ready = 1;
        took = 0;
        for (int n = 0; n < 8 && !took; n++) step();
        chk("t3_third_taken", 64'(took), 64'd1);
        valid = 0;
        repeat (3) step();
        chk("t3_drained", 64'(i16.dec_valid), 64'd0);
        // Illegal encodings still flow through
        valid = 1; word = 32'hFC000000;
        step();
        chk("t4_bad_op", 64'({i16.instr_class, i16.illegal}), 64'({2'd3, 1'b1}));
        word = 32'h0000003F;
        step();
        chk("t4_bad_fn", 64'({i16.instr_class, i16.illegal}), 64'({2'd3, 1'b1}));
        valid = 0;
        repeat (2) step();
        // Reset while FULL discards both entries
        ready = 0; valid = 1; word = rand_word();
        step();
        word = rand_word();
        step();
        chk("t5_full", 64'(i16.instr_ready), 64'd0);
        valid = 0; rst = 1;
        step();
        chk("t5_after_rst", 64'({i16.dec_valid, i16.instr_ready, i16.instr_count}), 64'({1'b0, 1'b1, 16'd0}));
        rst = 0; ready = 1;
        repeat (3) step();
        // 17 deliveries wrap the 4-bit counter to 1
        valid = 1;
        repeat (17) begin
            word = rand_word();
            step();
        end
        valid = 0;
        step();
        chk("t6_wrap4", 64'(i4.instr_count), 64'd1);
        chk("t6_count16", 64'(i16.instr_count), 64'd17);
        // Random traffic with occasional reset
        repeat (400) begin
            rst   = ($urandom_range(0, 49) == 0);
            valid = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            word  = rand_word();
            step();
        end
        rst = 0; valid = 0; ready = 1;
        repeat (4) step();
        chk("final_empty", 64'(i16.dec_valid), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
